// File: rtl/keccak_feeder_pkg.sv
// -----------------------------------------------------------------------------
// keccak_feeder_pkg
// Shared definitions for the Keccak message feeder: FSM state encoding and the
// default word geometry (bytes per Keccak input word, fill-count width).
// -----------------------------------------------------------------------------
package keccak_feeder_pkg;

  // Default geometry: 24-byte words, 6-bit counter (holds 0..WORD_BYTES).
  localparam int WORD_BYTES_DEF = 24;
  localparam int CNT_W_DEF      = 6;

  typedef enum logic [2:0] {
    ST_START    = 3'd0,  // pulse k_reset to the core
    ST_FILL     = 3'd1,  // accept message bytes into the word buffer
    ST_SEND     = 3'd2,  // full word, more message to follow
    ST_SEND_FL  = 3'd3,  // full word that ended the message; empty last word follows
    ST_LAST     = 3'd4,  // final (partial or empty) word
    ST_WAIT_OUT = 3'd5   // wait for the core's digest
  } state_e;

endpackage : keccak_feeder_pkg

// File: rtl/keccak_byte_packer.sv
// -----------------------------------------------------------------------------
// keccak_byte_packer
// Lane-indexed byte write register. Each write stores i_data into lane
// o_count (lane 0 occupies the MSBs of o_word) and advances the count.
// i_clr zeroes the word and the count.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   i_wr                write i_data into lane o_count, count++
//   i_data [7:0]        byte to write
//   i_clr               clear word and count (never asserted with i_wr)
//   o_word [8*WB-1:0]   packed word, first byte in MSBs
//   o_count [CNT_W-1:0] number of bytes currently held
// -----------------------------------------------------------------------------
module keccak_byte_packer
  import keccak_feeder_pkg::*;
#(
  parameter int WORD_BYTES = WORD_BYTES_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    i_wr,
  input  logic [7:0]              i_data,
  input  logic                    i_clr,
  output logic [8*WORD_BYTES-1:0] o_word,
  output logic [CNT_W-1:0]        o_count
);

  // Lane i lives at r_lanes[WORD_BYTES-1-i] so lane 0 lands in the MSBs.
  logic [WORD_BYTES-1:0][7:0] r_lanes;
  logic [CNT_W-1:0]           r_count;

  // NOTE: the lane register is reset (not left uninitialised like a RAM)
  // because the word is a visible output that must read zero out of reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lanes <= '0;
      r_count <= '0;
    end else if (i_clr) begin
      r_lanes <= '0;
      r_count <= '0;
    end else if (i_wr) begin
      // NOTE: non-blocking assignments keep every register update in this
      // block reading the pre-edge values, independent of statement order.
      for (int i = 0; i < WORD_BYTES; i++) begin
        if (r_count == CNT_W'(i)) r_lanes[WORD_BYTES-1-i] <= i_data;
      end
      r_count <= r_count + 1'b1;
    end
  end

  assign o_word  = r_lanes;
  assign o_count = r_count;

endmodule : keccak_byte_packer

// File: rtl/keccak_msg_feeder.sv
// -----------------------------------------------------------------------------
// keccak_msg_feeder
// Packs a byte stream (valid/ready, s_last marks the message end) into
// WORD_BYTES-wide words for a Keccak core, flags the final partial or empty
// word with its byte count, and waits for the digest before the next message.
//
// Optional feature: define KECCAK_FEEDER_STATS_EN to build the saturating
// message-length counter on msg_len; otherwise msg_len is tied to zero.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   s_data/valid/last   upstream byte stream; s_ready accepts a byte
//   k_reset             one-cycle active-high reset pulse to the core
//   k_in                packed word, first byte in MSBs
//   k_in_ready          word strobe (combinational; that cycle is the transfer)
//   k_is_last           strobed word is the final word
//   k_byte_num          valid bytes in the final word
//   k_buffer_full       core cannot accept a word
//   k_out_ready         core digest valid
//   busy                high except when idle in FILL with no bytes held
//   msg_done            one-cycle pulse when the digest is ready
//   msg_len             bytes in the current/last message (stats build only)
// -----------------------------------------------------------------------------
module keccak_msg_feeder
  import keccak_feeder_pkg::*;
#(
  parameter int WORD_BYTES = WORD_BYTES_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [7:0]              s_data,
  input  logic                    s_valid,
  input  logic                    s_last,
  output logic                    s_ready,
  output logic                    k_reset,
  output logic [8*WORD_BYTES-1:0] k_in,
  output logic                    k_in_ready,
  output logic                    k_is_last,
  output logic [CNT_W-1:0]        k_byte_num,
  input  logic                    k_buffer_full,
  input  logic                    k_out_ready,
  output logic                    busy,
  output logic                    msg_done,
  output logic [15:0]             msg_len
);

  state_e           r_state;
  state_e           w_state_nxt;
  logic             r_armed;      // low only until the first edge after reset
  logic             w_accept;
  logic             w_xfer;
  logic             w_clr;
  logic             w_word_fill;  // accepted byte completes the word
  logic [CNT_W-1:0] w_count;

  // State register. r_armed holds START without a k_reset pulse while reset
  // is asserted, so the pulse appears on the first cycle after release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_START;
      r_armed <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_armed <= 1'b1;
    end
  end

  assign s_ready     = (r_state == ST_FILL);
  assign w_accept    = s_valid && s_ready;
  assign w_word_fill = (w_count == CNT_W'(WORD_BYTES - 1));
  assign w_xfer      = !k_buffer_full &&
                       ((r_state == ST_SEND) || (r_state == ST_SEND_FL) ||
                        (r_state == ST_LAST));

  // NOTE: every output of this block gets a default first so no path leaves
  // a signal unassigned, which would infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_clr       = 1'b0;
    unique case (r_state)
      ST_START: begin
        w_clr = 1'b1;
        if (r_armed) w_state_nxt = ST_FILL;
      end
      ST_FILL: begin
        if (w_accept) begin
          if (s_last)           w_state_nxt = w_word_fill ? ST_SEND_FL : ST_LAST;
          else if (w_word_fill) w_state_nxt = ST_SEND;
        end
      end
      ST_SEND: begin
        if (w_xfer) begin
          w_clr       = 1'b1;
          w_state_nxt = ST_FILL;
        end
      end
      ST_SEND_FL: begin
        // The full word did not carry the end marker, so an empty final
        // word follows it.
        if (w_xfer) begin
          w_clr       = 1'b1;
          w_state_nxt = ST_LAST;
        end
      end
      ST_LAST: begin
        if (w_xfer) w_state_nxt = ST_WAIT_OUT;
      end
      ST_WAIT_OUT: begin
        if (k_out_ready) w_state_nxt = ST_START;
      end
      default: w_state_nxt = ST_START;
    endcase
  end

  keccak_byte_packer #(
    .WORD_BYTES (WORD_BYTES),
    .CNT_W      (CNT_W)
  ) u_packer (
    .clk     (clk),
    .reset_n (reset_n),
    .i_wr    (w_accept),
    .i_data  (s_data),
    .i_clr   (w_clr),
    .o_word  (k_in),
    .o_count (w_count)
  );

  assign k_reset    = r_armed && (r_state == ST_START);
  assign k_in_ready = w_xfer;
  assign k_is_last  = w_xfer && (r_state == ST_LAST);
  assign k_byte_num = k_is_last ? w_count : '0;
  assign msg_done   = (r_state == ST_WAIT_OUT) && k_out_ready;
  assign busy       = r_armed && !((r_state == ST_FILL) && (w_count == '0));

`ifdef KECCAK_FEEDER_STATS_EN
  logic [15:0] r_msg_len;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_msg_len <= '0;
    end else if (r_state == ST_START) begin
      r_msg_len <= '0;
    end else if (w_accept && (r_msg_len != 16'hFFFF)) begin
      r_msg_len <= r_msg_len + 16'd1;
    end
  end

  assign msg_len = r_msg_len;
`else
  assign msg_len = '0;
`endif

endmodule : keccak_msg_feeder

// File: tb/tb_keccak_msg_feeder.sv
// -----------------------------------------------------------------------------
// tb_keccak_msg_feeder
// Self-checking bench for keccak_msg_feeder (default WORD_BYTES=24, CNT_W=6).
// Expected words are queued when a message is issued; a monitor pops and
// compares whenever k_in_ready is high. Honors KECCAK_FEEDER_STATS_EN for the
// expected msg_len.
// -----------------------------------------------------------------------------
module tb_keccak_msg_feeder;

  localparam int WB = 24;
  localparam int CW = 6;

  typedef struct {
    logic [8*WB-1:0] word;
    logic            last;
    logic [CW-1:0]   num;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [7:0]      s_data;
  logic            s_valid;
  logic            s_last;
  logic            s_ready;
  logic            k_reset;
  logic [8*WB-1:0] k_in;
  logic            k_in_ready;
  logic            k_is_last;
  logic [CW-1:0]   k_byte_num;
  logic            k_buffer_full;
  logic            k_out_ready;
  logic            busy;
  logic            msg_done;
  logic [15:0]     msg_len;

  int n_chk = 0;
  int n_err = 0;

  exp_t        sb[$];
  logic [7:0]  msg_q[$];

  keccak_msg_feeder #(.WORD_BYTES(WB), .CNT_W(CW)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .s_data        (s_data),
    .s_valid       (s_valid),
    .s_last        (s_last),
    .s_ready       (s_ready),
    .k_reset       (k_reset),
    .k_in          (k_in),
    .k_in_ready    (k_in_ready),
    .k_is_last     (k_is_last),
    .k_byte_num    (k_byte_num),
    .k_buffer_full (k_buffer_full),
    .k_out_ready   (k_out_ready),
    .busy          (busy),
    .msg_done      (msg_done),
    .msg_len       (msg_len)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [8*WB-1:0] act,
                       input logic [8*WB-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] exp_len(input int n);
`ifdef KECCAK_FEEDER_STATS_EN
    return 16'(n);
`else
    return 16'(n * 0);
`endif
  endfunction

  // Reference packing of msg_q: full words, then a final word (possibly empty).
  task automatic expect_msg();
    int   n    = msg_q.size();
    int   full = n / WB;
    int   rem  = n % WB;
    exp_t e;
    for (int f = 0; f < full; f++) begin
      e.word = '0;
      for (int b = 0; b < WB; b++) e.word[8*WB-1-8*b -: 8] = msg_q[f*WB+b];
      e.last = 1'b0;
      e.num  = '0;
      sb.push_back(e);
    end
    e.word = '0;
    for (int b = 0; b < rem; b++) e.word[8*WB-1-8*b -: 8] = msg_q[full*WB+b];
    e.last = 1'b1;
    e.num  = CW'(rem);
    sb.push_back(e);
  endtask

  task automatic push_exp(input logic [8*WB-1:0] w, input logic l,
                          input logic [CW-1:0] n);
    exp_t e;
    e.word = w;
    e.last = l;
    e.num  = n;
    sb.push_back(e);
  endtask

  // Offer one byte; returns #1 after the edge that accepted it.
  task automatic send_byte(input logic [7:0] b, input logic last);
    logic ok;
    int   n = 0;
    s_data  = b;
    s_valid = 1'b1;
    s_last  = last;
    do begin
      @(negedge clk);
      ok = s_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 200);
    if (!ok) check("s_ready_timeout", {191'd0, ok}, 1);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_msg(input bit gap);
    for (int i = 0; i < msg_q.size(); i++) begin
      send_byte(msg_q[i], i == msg_q.size() - 1);
      if (gap) begin
        // Invalid cycle with s_last high must be ignored.
        s_last = 1'b1;
        @(posedge clk);
        #1;
        s_last = 1'b0;
      end
    end
  endtask

  // Wait for all expected words, then complete the digest handshake.
  task automatic finish_msg(input int nbytes);
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (sb.size() != 0 && n < 500);
    check("drain_left", 192'(sb.size()), 0);
    check("wait_busy", {191'd0, busy}, 1);
    check("wait_no_done", {191'd0, msg_done}, 0);
    check("msg_len", {176'd0, msg_len}, {176'd0, exp_len(nbytes)});
    k_out_ready = 1'b1;
    #1;
    check("msg_done", {191'd0, msg_done}, 1);
    @(posedge clk);
    #1;
    k_out_ready = 1'b0;
    check("msg_done_pulse", {191'd0, msg_done}, 0);
    check("k_reset_start", {191'd0, k_reset}, 1);
    check("start_s_ready", {191'd0, s_ready}, 0);
    @(posedge clk);
    #1;
    check("k_reset_off", {191'd0, k_reset}, 0);
    check("idle_busy", {191'd0, busy}, 0);
    check("msg_len_clr", {176'd0, msg_len}, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_s_ready"}, {191'd0, s_ready}, 0);
    check({tag, "_k_reset"}, {191'd0, k_reset}, 0);
    check({tag, "_k_in"}, k_in, 0);
    check({tag, "_k_in_ready"}, {191'd0, k_in_ready}, 0);
    check({tag, "_k_is_last"}, {191'd0, k_is_last}, 0);
    check({tag, "_k_byte_num"}, {186'd0, k_byte_num}, 0);
    check({tag, "_busy"}, {191'd0, busy}, 0);
    check({tag, "_msg_done"}, {191'd0, msg_done}, 0);
    check({tag, "_msg_len"}, {176'd0, msg_len}, 0);
  endtask

  // Monitor: every strobe consumes one expected word.
  always @(negedge clk) begin
    if (k_in_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_strobe", {191'd0, k_in_ready}, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("k_in", k_in, e.word);
        check("k_is_last", {191'd0, k_is_last}, {191'd0, e.last});
        check("k_byte_num", {186'd0, k_byte_num}, {186'd0, e.num});
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    exp_t     dummy;
    logic [8*WB-1:0] full_w;
    reset_n       = 1'b0;
    s_data        = '0;
    s_valid       = 1'b0;
    s_last        = 1'b0;
    k_buffer_full = 1'b0;
    k_out_ready   = 1'b0;
    dummy.word    = '0;
    #2;
    check_reset_outputs("por");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("first_k_reset", {191'd0, k_reset}, 1);
    check("first_busy", {191'd0, busy}, 1);
    @(posedge clk);
    #1;
    check("fill_k_reset", {191'd0, k_reset}, 0);
    check("fill_s_ready", {191'd0, s_ready}, 1);

    // 23-byte message: one final word, 23 bytes, last lane zero.
    msg_q.delete();
    for (int r = 0; r < 3; r++) begin
      msg_q.push_back(8'h90); msg_q.push_back(8'hAB); msg_q.push_back(8'hCD);
      msg_q.push_back(8'hEF); msg_q.push_back(8'h1A); msg_q.push_back(8'h1B);
      msg_q.push_back(8'h1C); msg_q.push_back(8'h1D);
    end
    void'(msg_q.pop_back());
    push_exp(192'h90ABCDEF1A1B1C1D_90ABCDEF1A1B1C1D_90ABCDEF1A1B1C00, 1'b1, 6'd23);
    send_msg(1'b0);
    finish_msg(23);

    // 24-byte message: full word, then an empty final word.
    msg_q.delete();
    for (int i = 1; i <= 24; i++) msg_q.push_back(8'(i));
    push_exp(192'h0102030405060708090A0B0C0D0E0F101112131415161718, 1'b0, 6'd0);
    push_exp(192'h0, 1'b1, 6'd0);
    send_msg(1'b0);
    finish_msg(24);

    // 50-byte message: two full words, final word carries bytes 49, 50.
    msg_q.delete();
    for (int i = 1; i <= 50; i++) msg_q.push_back(8'(i));
    expect_msg();
    send_msg(1'b0);
    finish_msg(50);

    // Back-pressure: k_buffer_full held for 10 cycles in SEND.
    msg_q.delete();
    for (int i = 0; i < 25; i++) msg_q.push_back(8'(i * 3 + 5));
    expect_msg();
    full_w = sb[0].word;
    for (int i = 0; i < 23; i++) send_byte(msg_q[i], 1'b0);
    k_buffer_full = 1'b1;
    send_byte(msg_q[23], 1'b0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("stall_k_in_ready", {191'd0, k_in_ready}, 0);
      check("stall_s_ready", {191'd0, s_ready}, 0);
      check("stall_k_in", k_in, full_w);
      check("stall_k_byte_num", {186'd0, k_byte_num}, 0);
    end
    @(posedge clk);
    #1;
    k_buffer_full = 1'b0;
    #1;
    check("release_strobe", {191'd0, k_in_ready}, 1);
    send_byte(msg_q[24], 1'b1);
    finish_msg(25);

    // s_valid every other cycle; invalid s_last in the gaps.
    msg_q.delete();
    for (int i = 0; i < 30; i++) msg_q.push_back(8'(i * 7 + 3));
    expect_msg();
    send_msg(1'b1);
    finish_msg(30);

    // Reset mid-message: partial data discarded, clean restart.
    for (int i = 0; i < 10; i++) send_byte(8'(8'hC0 + i), 1'b0);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("mid");
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_k_reset", {191'd0, k_reset}, 1);
    @(posedge clk);
    #1;
    check("rst_fill_s_ready", {191'd0, s_ready}, 1);
    msg_q.delete();
    for (int i = 0; i < 5; i++) msg_q.push_back(8'(8'h50 + i));
    push_exp(192'h5051525354 << (8 * 19), 1'b1, 6'd5);
    send_msg(1'b0);
    finish_msg(5);

    repeat (3) @(posedge clk);
    check("sb_empty_end", 192'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule : tb_keccak_msg_feeder

// File: doc/keccak_msg_feeder.md
KECCAK_MSG_FEEDER -- requirements
Module: keccak_msg_feeder

Interface
REQ-001 SHALL have parameter WORD_BYTES, default 24, bytes per Keccak input word (k_in width = 8*WORD_BYTES).
REQ-002 SHALL have parameter CNT_W, default 6, width of k_byte_num and the internal fill count.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 reset_n  in  1  reset, asynchronous, active-low.
REQ-005 s_data  in  8  message byte, upstream stream.
REQ-006 s_valid  in  1  s_data valid.
REQ-007 s_last  in  1  s_data is final byte of message; meaningful only with s_valid.
REQ-008 s_ready  out  1  byte accepted when s_valid&&s_ready.
REQ-009 k_reset  out  1  active-high, one-cycle reset to the keccak core.
REQ-010 k_in  out  8*WORD_BYTES  packed word; first byte in MSBs.
REQ-011 k_in_ready  out  1  word strobe to keccak.
REQ-012 k_is_last  out  1  word is final (partial or empty) word.
REQ-013 k_byte_num  out  CNT_W  valid bytes in final word, 0..WORD_BYTES-1.
REQ-014 k_buffer_full  in  1  keccak cannot accept a word.
REQ-015 k_out_ready  in  1  keccak digest valid.
REQ-016 busy  out  1  high in every state except FILL with count 0.
REQ-017 msg_done  out  1  one-cycle pulse when digest is ready.
REQ-018 msg_len  out  16  bytes of current/last message (see Configuration).

Function
REQ-019 FSM states: START, FILL, SEND, SEND_FL, LAST, WAIT_OUT.
REQ-020 START: k_reset=1 for exactly one cycle, then FILL, count=0.
REQ-021 FILL: s_ready=1; each accepted byte is written to k_in byte lane count (lane 0 = bits [8*WORD_BYTES-1 -: 8]), count++; one byte per cycle max.
REQ-022 FILL, accepted byte without s_last bringing count to WORD_BYTES -> SEND.
REQ-023 FILL, accepted byte with s_last: count+1<WORD_BYTES -> LAST; count+1==WORD_BYTES -> SEND_FL.
REQ-024 SEND/SEND_FL/LAST/WAIT_OUT/START: s_ready=0; k_in held stable.
REQ-025 k_in_ready SHALL be combinational: 1 iff state in {SEND,SEND_FL,LAST} and k_buffer_full==0; that same cycle is the transfer.
REQ-026 SEND transfer: k_is_last=0, k_byte_num=0; then FILL, count=0, k_in cleared.
REQ-027 SEND_FL transfer: k_is_last=0; then LAST with count=0, k_in=0 (empty final word).
REQ-028 LAST transfer: k_is_last=1, k_byte_num=count, lanes >=count zero; then WAIT_OUT.
REQ-029 k_is_last and k_byte_num SHALL be 0 whenever k_in_ready is 0.
REQ-030 WAIT_OUT: on k_out_ready==1 -> msg_done=1 that cycle, next state START.
REQ-031 s_last without s_valid SHALL be ignored; k_buffer_full outside send states ignored.

Reset
REQ-032 reset_n low SHALL asynchronously force state=START-pending (k_reset=0), count=0, k_in=0, s_ready=0, k_in_ready=0, k_is_last=0, k_byte_num=0, busy=0, msg_done=0, msg_len=0.
REQ-033 First cycle after reset_n release: k_reset pulse (START), then FILL.
REQ-034 Reset mid-message SHALL discard partial data; no k_in_ready pulse for it.

Configuration
REQ-035 Macro KECCAK_FEEDER_STATS_EN defined: msg_len counts accepted bytes, clears in START, saturates at 16'hFFFF, holds after LAST until next START.
REQ-036 Macro undefined: msg_len tied to 0, counter not built.

Structure
REQ-037 Package keccak_feeder_pkg SHALL hold the state enum, WORD_BYTES and CNT_W defaults.
REQ-038 One sub-module keccak_byte_packer: lane-indexed byte write register, fill count, clear.

Verification
REQ-039 23 bytes 90 AB CD EF 1A 1B 1C 1D x3 minus last, s_last on 23rd -> one strobe, k_is_last=1, k_byte_num=23, k_in=0x90ABCDEF1A1B1C1D90ABCDEF1A1B1C1D90ABCDEF1A1B1C00; k_out_ready -> msg_done pulse.
REQ-040 24-byte message -> strobe k_is_last=0 full word, then strobe k_is_last=1, k_byte_num=0, k_in=0.
REQ-041 50-byte message -> two full-word strobes then final strobe k_byte_num=2, bytes 49,50 in lanes 0,1; msg_len=50 with macro, 0 without.
REQ-042 k_buffer_full=1 for 10 cycles in SEND -> k_in_ready=0, s_ready=0, k_in stable; strobe on first cycle k_buffer_full=0.
REQ-043 reset_n low after 10 bytes -> all outputs reset values immediately; after release, k_reset pulse, next 5-byte message gives k_byte_num=5.
REQ-044 s_valid toggled every other cycle -> bytes packed in order, no gaps or duplicates.
